// File: rtl/hier_walker_pkg.sv
// Shared definitions for the pre-order tree walker: FSM state encoding and
// the default geometry of node indices and the ancestor stack.
package hier_walker_pkg;

  localparam int IDX_W_DEF     = 8;
  localparam int MAX_DEPTH_DEF = 8;

  localparam logic [IDX_W_DEF-1:0] NULL_IDX_DEF = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_POP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hier_walker_stack.sv
// LIFO of pending next-sibling pointers. The entry on top is visible
// combinationally on o_pop_data.
module hier_walker_stack #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_push_data,
  output logic [W-1:0]     o_pop_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;

  assign w_wr_ptr = r_count[PTR_W-1:0];
  assign w_rd_ptr = PTR_W'(r_count - CNT_W'(1));

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values; mixing in = here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_push) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; only r_count decides
  // which entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_ptr] <= i_push_data;
    end
  end

  assign o_pop_data = r_mem[w_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/hier_walker.sv
// Pre-order depth-first walker over a first-child/next-sibling tree held in
// an external node memory; emits one visit event per node read.
module hier_walker
  import hier_walker_pkg::*;
#(
  parameter  int               IDX_W     = IDX_W_DEF,
  parameter  int               MAX_DEPTH = MAX_DEPTH_DEF,
  parameter  logic [IDX_W-1:0] NULL_IDX  = '1,
  localparam int               DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   root_idx,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [IDX_W-1:0]   mem_req_idx,
  input  logic               mem_rsp_valid,
  input  logic [IDX_W-1:0]   mem_rsp_child,
  input  logic [IDX_W-1:0]   mem_rsp_sibling,
  output logic               visit_valid,
  input  logic               visit_ready,
  output logic [IDX_W-1:0]   visit_idx,
  output logic [DEPTH_W-1:0] visit_depth,
  output logic               visit_leaf
);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cur, w_cur_nxt;
  logic [IDX_W-1:0]   r_child, w_child_nxt;
  logic [IDX_W-1:0]   r_sib, w_sib_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
  logic               r_error, w_error_nxt;

  logic               w_clear, w_push, w_pop;
  logic [IDX_W-1:0]   w_pop_data;
  logic [DEPTH_W-1:0] w_count;
  logic               w_empty, w_full;

  hier_walker_stack #(
    .DEPTH (MAX_DEPTH),
    .W     (IDX_W)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (r_sib),
    .o_pop_data  (w_pop_data),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_child <= '0;
      r_sib   <= '0;
      r_depth <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_child <= w_child_nxt;
      r_sib   <= w_sib_nxt;
      r_depth <= w_depth_nxt;
      r_error <= w_error_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_child_nxt = r_child;
    w_sib_nxt   = r_sib;
    w_depth_nxt = r_depth;
    w_error_nxt = r_error;
    w_clear     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_error_nxt = 1'b0;
          w_depth_nxt = '0;
          w_cur_nxt   = root_idx;
          w_state_nxt = (root_idx == NULL_IDX) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          w_child_nxt = mem_rsp_child;
          // Only the root lives at depth 0; its siblings are outside the walk.
          w_sib_nxt   = (r_depth == '0) ? NULL_IDX : mem_rsp_sibling;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (visit_ready) begin
          if (r_child != NULL_IDX) begin
            if (w_full) begin
              w_error_nxt = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_push      = 1'b1;
              w_cur_nxt   = r_child;
              w_depth_nxt = r_depth + DEPTH_W'(1);
              w_state_nxt = ST_REQ;
            end
          end else if (r_sib != NULL_IDX) begin
            w_cur_nxt   = r_sib;
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_POP;
          end
        end
      end
      ST_POP: begin
        if (w_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_pop       = 1'b1;
          w_depth_nxt = w_count - DEPTH_W'(1);
          if (w_pop_data != NULL_IDX) begin
            w_cur_nxt   = w_pop_data;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done          = (r_state == ST_DONE);
  assign error         = r_error;
  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_idx   = r_cur;
  assign visit_valid   = (r_state == ST_EMIT);
  assign visit_idx     = r_cur;
  assign visit_depth   = r_depth;
  assign visit_leaf    = visit_valid && (r_child == NULL_IDX);

endmodule

// File: tb/tb_hier_walker.sv
// Directed bench for hier_walker: table-driven node memory, stallable
// request/visit handshakes, and hand-computed expected visit sequences.
module tb_hier_walker;
  import hier_walker_pkg::*;

  localparam logic [7:0] NUL = NULL_IDX_DEF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] root_idx;
  logic       busy, done, error;
  logic       mem_req_valid;
  logic       mem_req_ready = 1'b0;
  logic [7:0] mem_req_idx;
  logic       mem_rsp_valid = 1'b0;
  logic [7:0] mem_rsp_child = 8'hA5;
  logic [7:0] mem_rsp_sibling = 8'h5A;
  logic       visit_valid;
  logic       visit_ready = 1'b0;
  logic [7:0] visit_idx;
  logic [3:0] visit_depth;
  logic       visit_leaf;

  hier_walker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .root_idx        (root_idx),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_idx     (mem_req_idx),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_child   (mem_rsp_child),
    .mem_rsp_sibling (mem_rsp_sibling),
    .visit_valid     (visit_valid),
    .visit_ready     (visit_ready),
    .visit_idx       (visit_idx),
    .visit_depth     (visit_depth),
    .visit_leaf      (visit_leaf)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Node memory contents and handshake shaping, set by the directed steps.
  logic [7:0] child_tab [256];
  logic [7:0] sib_tab   [256];
  int req_stall = 0;
  int rsp_lat   = 1;
  int vis_stall = 0;

  // Memory responder: one outstanding request, fixed latency, optional stalls.
  int         req_count   = 0;
  bit         rsp_pending = 1'b0;
  int         rsp_wait    = 0;
  logic [7:0] rsp_idx     = '0;
  int         req_left    = 0;
  bit         req_stalled = 1'b0;
  logic [7:0] req_held    = '0;

  always @(negedge clk) begin
    mem_rsp_valid   = 1'b0;
    mem_rsp_child   = 8'hA5;
    mem_rsp_sibling = 8'h5A;
    if (rsp_pending) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        mem_rsp_valid   = 1'b1;
        mem_rsp_child   = child_tab[rsp_idx];
        mem_rsp_sibling = sib_tab[rsp_idx];
        rsp_pending     = 1'b0;
      end
    end
    if (mem_req_valid) begin
      if (req_stalled) check("req_idx_stable", mem_req_idx, req_held);
      if (req_left > 0 || rsp_pending) begin
        mem_req_ready = 1'b0;
        if (req_left > 0) req_left--;
        req_stalled = 1'b1;
        req_held    = mem_req_idx;
      end else begin
        mem_req_ready = 1'b1;
        rsp_pending   = 1'b1;
        rsp_wait      = rsp_lat;
        rsp_idx       = mem_req_idx;
        req_count++;
        req_stalled   = 1'b0;
      end
    end else begin
      mem_req_ready = 1'b0;
      req_left      = req_stall;
      req_stalled   = 1'b0;
    end
  end

  // Visitor: records accepted events and checks outputs hold while stalled.
  logic [7:0] got_idx  [$];
  logic [3:0] got_dep  [$];
  logic       got_leaf [$];
  int         vis_left    = 0;
  bit         vis_stalled = 1'b0;
  logic [7:0] vh_idx      = '0;
  logic [3:0] vh_dep      = '0;
  logic       vh_leaf     = 1'b0;

  always @(negedge clk) begin
    if (visit_valid) begin
      if (vis_stalled) begin
        check("visit_idx_stable", visit_idx, vh_idx);
        check("visit_depth_stable", visit_depth, vh_dep);
        check("visit_leaf_stable", visit_leaf, vh_leaf);
      end
      if (vis_left > 0) begin
        visit_ready = 1'b0;
        vis_left--;
        vis_stalled = 1'b1;
        vh_idx      = visit_idx;
        vh_dep      = visit_depth;
        vh_leaf     = visit_leaf;
      end else begin
        visit_ready = 1'b1;
        got_idx.push_back(visit_idx);
        got_dep.push_back(visit_depth);
        got_leaf.push_back(visit_leaf);
        vis_stalled = 1'b0;
      end
    end else begin
      visit_ready = (vis_stall == 0);
      vis_left    = vis_stall;
      vis_stalled = 1'b0;
    end
  end

  logic [7:0] exp_idx  [16];
  logic [3:0] exp_dep  [16];
  logic       exp_leaf [16];
  int         exp_n = 0;

  task automatic clear_run();
    got_idx.delete();
    got_dep.delete();
    got_leaf.delete();
    exp_n     = 0;
    req_count = 0;
  endtask

  task automatic add_exp(input logic [7:0] idx, input logic [3:0] dep, input logic leaf);
    exp_idx[exp_n]  = idx;
    exp_dep[exp_n]  = dep;
    exp_leaf[exp_n] = leaf;
    exp_n++;
  endtask

  task automatic compare_visits(input string tag);
    check($sformatf("%s_count", tag), got_idx.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (i < got_idx.size()) begin
        check($sformatf("%s_idx%0d", tag, i), got_idx[i], exp_idx[i]);
        check($sformatf("%s_dep%0d", tag, i), got_dep[i], exp_dep[i]);
        check($sformatf("%s_leaf%0d", tag, i), got_leaf[i], exp_leaf[i]);
      end
    end
  endtask

  // Pulse start, then wait (bounded) for done and confirm it lasts one cycle.
  task automatic run_walk(input string tag, input logic [7:0] root, output int cycles);
    @(negedge clk);
    start    = 1'b1;
    root_idx = root;
    @(negedge clk);
    start    = 1'b0;
    root_idx = 8'h00;
    cycles   = 1;
    check($sformatf("%s_busy_after_start", tag), busy, (root != NUL));
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check($sformatf("%s_done_seen", tag), done, 1'b1);
    check($sformatf("%s_busy_in_done", tag), busy, 1'b0);
    @(negedge clk);
    check($sformatf("%s_done_one_cycle", tag), done, 1'b0);
  endtask

  initial begin
    int cyc;
    rst_n    = 1'b0;
    start    = 1'b0;
    root_idx = 8'h00;
    for (int i = 0; i < 256; i++) begin
      child_tab[i] = NUL;
      sib_tab[i]   = NUL;
    end

    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_visit_valid", visit_valid, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single leaf root.
    clear_run();
    add_exp(8'd5, 4'd0, 1'b1);
    run_walk("single", 8'd5, cyc);
    compare_visits("single");
    check("single_error", error, 1'b0);
    check("single_reqs", req_count, 1);

    // Tree 0->{1,2}, 1->{3}; root sibling holds junk that must be ignored.
    child_tab[0] = 8'd1;  sib_tab[0] = 8'd6;
    child_tab[1] = 8'd3;  sib_tab[1] = 8'd2;
    clear_run();
    add_exp(8'd0, 4'd0, 1'b0);
    add_exp(8'd1, 4'd1, 1'b0);
    add_exp(8'd3, 4'd2, 1'b1);
    add_exp(8'd2, 4'd1, 1'b1);
    run_walk("tree", 8'd0, cyc);
    compare_visits("tree");
    check("tree_error", error, 1'b0);

    // Same tree with back-pressure on both interfaces and slow memory.
    req_stall = 2;
    rsp_lat   = 4;
    vis_stall = 3;
    clear_run();
    add_exp(8'd0, 4'd0, 1'b0);
    add_exp(8'd1, 4'd1, 1'b0);
    add_exp(8'd3, 4'd2, 1'b1);
    add_exp(8'd2, 4'd1, 1'b1);
    run_walk("stall", 8'd0, cyc);
    compare_visits("stall");
    check("stall_reqs", req_count, 4);
    req_stall = 0;
    rsp_lat   = 2;
    vis_stall = 0;

    // Chain of nine nodes fills the stack exactly.
    clear_run();
    for (int i = 0; i < 9; i++) begin
      child_tab[10 + i] = (i < 8) ? 8'(11 + i) : NUL;
      add_exp(8'(10 + i), 4'(i), (i == 8));
    end
    run_walk("chain9", 8'd10, cyc);
    compare_visits("chain9");
    check("chain9_error", error, 1'b0);

    // Chain of ten nodes overflows on the ninth visit.
    clear_run();
    for (int i = 0; i < 10; i++) begin
      child_tab[20 + i] = (i < 9) ? 8'(21 + i) : NUL;
      if (i < 9) add_exp(8'(20 + i), 4'(i), 1'b0);
    end
    run_walk("chain10", 8'd20, cyc);
    compare_visits("chain10");
    check("chain10_error", error, 1'b1);
    repeat (3) @(negedge clk);
    check("chain10_error_sticky", error, 1'b1);
    check("chain10_idle_busy", busy, 1'b0);

    // Null root: no request, no visit, done right after start, error cleared.
    clear_run();
    run_walk("nullroot", NUL, cyc);
    check("nullroot_latency", cyc, 1);
    check("nullroot_error_cleared", error, 1'b0);
    check("nullroot_reqs", req_count, 0);
    compare_visits("nullroot");

    // Reset while waiting for a response; the late response must be dropped.
    rsp_lat = 4;
    child_tab[30] = 8'd31;
    clear_run();
    @(negedge clk);
    start    = 1'b1;
    root_idx = 8'd30;
    @(negedge clk);
    start    = 1'b0;
    root_idx = 8'h00;
    cyc      = 0;
    while (!(busy && !mem_req_valid) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rstwait_reached_wait", busy && !mem_req_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwait_busy", busy, 1'b0);
    check("rstwait_done", done, 1'b0);
    check("rstwait_error", error, 1'b0);
    check("rstwait_req_valid", mem_req_valid, 1'b0);
    check("rstwait_visit_valid", visit_valid, 1'b0);
    check("rstwait_req_idx", mem_req_idx, 8'h00);
    check("rstwait_visit_idx", visit_idx, 8'h00);
    check("rstwait_visit_depth", visit_depth, 4'h0);
    check("rstwait_visit_leaf", visit_leaf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("late_rsp_no_visit", got_idx.size(), 0);
    check("late_rsp_busy", busy, 1'b0);
    check("late_rsp_visit_valid", visit_valid, 1'b0);

    // Fresh traversal after the abandoned one: 7->{8,9}.
    child_tab[7] = 8'd8;
    sib_tab[8]   = 8'd9;
    clear_run();
    add_exp(8'd7, 4'd0, 1'b0);
    add_exp(8'd8, 4'd1, 1'b1);
    add_exp(8'd9, 4'd1, 1'b1);
    run_walk("fresh", 8'd7, cyc);
    compare_visits("fresh");
    check("fresh_error", error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
